// File: rtl/axis_avst_frame_bridge.sv
// AXI4-Stream video sink to Avalon-ST source bridge with a show-ahead FIFO,
// frame-aligned start/stop gating and CSR statistics. Optional LED: STATUS_LED_EN.
module axis_avst_frame_bridge #(
    parameter int DATA_W     = 24,
    parameter int USER_W     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int LED_DIV_W  = 4
) (
    input  logic              clock_sink_clk,
    input  logic              reset_sink_reset,
    input  logic [DATA_W-1:0] axi4stream_slave_tdata,
    input  logic [USER_W-1:0] axi4stream_slave_tuser,
    input  logic              axi4stream_slave_tvalid,
    input  logic              axi4stream_slave_tlast,
    output logic              axi4stream_slave_tready,
    output logic [DATA_W-1:0] avalon_streaming_source_data,
    output logic              avalon_streaming_source_startofpacket,
    output logic              avalon_streaming_source_endofpacket,
    output logic              avalon_streaming_source_valid,
    input  logic              avalon_streaming_source_ready,
    input  logic [7:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic              status_led
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = DATA_W + 2;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PASS     = 2'd2
    } state_t;

    state_t        state;
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          acc;
    logic          sof;
    logic          push;
    logic          pop;
    logic          drop;
    logic          frame_inc;
    logic          ctrl_enable;
    logic          clr;
    logic [31:0]   frame_count;
    logic [31:0]   drop_count;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign axi4stream_slave_tready = (state == PASS) ? !full : 1'b1;
    assign acc = axi4stream_slave_tvalid & axi4stream_slave_tready;
    assign sof = axi4stream_slave_tuser[0];
    assign pop = avalon_streaming_source_valid & avalon_streaming_source_ready;
    assign clr = csr_write && (csr_address == 8'd0) && csr_writedata[1];

    assign avalon_streaming_source_valid = !empty;
    assign {avalon_streaming_source_endofpacket,
            avalon_streaming_source_startofpacket,
            avalon_streaming_source_data} = mem[rd_ptr];

    always_comb begin
        push      = 1'b0;
        drop      = 1'b0;
        frame_inc = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (acc && sof && ctrl_enable) begin
                    push      = 1'b1;
                    frame_inc = 1'b1;
                end else begin
                    drop = acc;
                end
            end
            PASS: begin
                // A new SOF with enable low is where the stream stops
                if (acc && sof && !ctrl_enable) begin
                    drop = 1'b1;
                end else begin
                    push      = acc;
                    frame_inc = acc & sof;
                end
            end
            default: drop = acc;
        endcase
    end

    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (ctrl_enable) state <= WAIT_SOF;
                WAIT_SOF: begin
                    if (!ctrl_enable)   state <= IDLE;
                    else if (acc && sof) state <= PASS;
                end
                PASS:     if (acc && sof && !ctrl_enable) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_sink_clk) begin
        if (push) mem[wr_ptr] <= {axi4stream_slave_tlast, sof, axi4stream_slave_tdata};
    end

    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            ctrl_enable <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (csr_write && csr_address == 8'd0) ctrl_enable <= csr_writedata[0];
            if (clr) begin
                frame_count <= '0;
                drop_count  <= '0;
            end else begin
                if (frame_inc) frame_count <= frame_count + 32'd1;
                if (drop)      drop_count  <= drop_count + 32'd1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            8'd0:    rd_mux = {31'd0, ctrl_enable};
            8'd1:    rd_mux = {15'd0, 9'(level), 4'd0, full, empty, state};
            8'd2:    rd_mux = frame_count;
            8'd3:    rd_mux = drop_count;
            8'd4:    rd_mux = {15'd0, 9'(FIFO_DEPTH), 8'(DATA_W)};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset)  csr_readdata <= '0;
        else if (csr_read)     csr_readdata <= rd_mux;
    end

`ifdef STATUS_LED_EN
    logic [LED_DIV_W-1:0] led_cnt;
    logic                 led_q;

    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            led_cnt <= '0;
            led_q   <= 1'b0;
        end else if (frame_inc && !clr) begin
            led_cnt <= led_cnt + 1'b1;
            if (led_cnt == '1) led_q <= !led_q;
        end
    end

    assign status_led = led_q;
`else
    assign status_led = 1'b0;
`endif

    assign unused_bits = ^{axi4stream_slave_tuser, csr_writedata[31:2], 32'(LED_DIV_W)};
endmodule

// File: doc/axis_avst_frame_bridge.md
Name: axis_avst_frame_bridge

Overview:
Parametrised AXI4-Stream video sink to Avalon-ST source bridge with an internal show-ahead FIFO and CSR-controlled, frame-aligned start/stop gating. It adds packet markers, per-frame and per-drop statistics, and an optional frame-activity LED. It sits between the upstream video pipeline and the Avalon-ST consumer. It is controlled by the Nios/host over a simple CSR slave.

Parameters:
DATA_W, 24, pixel/beat data width (8..64)
USER_W, 3, tuser width; tuser[0] = start-of-frame (>=1)
FIFO_DEPTH, 16, FIFO entries; power of two, 4..256
LED_DIV_W, 4, width of LED toggle divider: LED toggles every 2^LED_DIV_W frames

Ports:
clock_sink_clk  in  1  single clock, all logic rising-edge
reset_sink_reset  in  1  synchronous, active-high reset
axi4stream_slave_tdata  in  DATA_W  input beat
axi4stream_slave_tuser  in  USER_W  bit0 = SOF; other bits ignored
axi4stream_slave_tvalid  in  1  input valid
axi4stream_slave_tlast  in  1  end of line
axi4stream_slave_tready  out  1  input ready
avalon_streaming_source_data  out  DATA_W  output beat
avalon_streaming_source_startofpacket  out  1  SOF of head beat
avalon_streaming_source_endofpacket  out  1  tlast of head beat
avalon_streaming_source_valid  out  1  FIFO not empty
avalon_streaming_source_ready  in  1  sink ready (ready latency 0)
csr_address  in  8  word index
csr_write  in  1  write strobe
csr_writedata  in  32  write data
csr_read  in  1  read strobe
csr_readdata  out  32  read data, registered
status_led  out  1  frame-activity indicator

Behaviour:
- Reset: FSM = IDLE; FIFO empty; all counters 0; CTRL = 0; csr_readdata = 0; status_led = 0; tready = 1; source valid = 0.
- FIFO: DATA_W+2 wide, holds {eop, sop, data}, sop = tuser[0], eop = tlast. Push = tvalid & tready & gate open. Pop = valid & ready. Push and pop may occur in the same cycle; level is unchanged.
- Latency: an accepted beat reaches the source outputs one cycle after acceptance when the FIFO was empty. Outputs are held stable while valid=1 and ready=0.
- FSM, 2-bit, encoded IDLE=0, WAIT_SOF=1, PASS=2:
  IDLE: tready=1, all beats discarded, counted in DROP_COUNT. CTRL.enable=1 -> WAIT_SOF.
  WAIT_SOF: tready=1. Non-SOF beats are discarded and counted. An accepted SOF beat is pushed and FRAME_COUNT increments -> PASS. enable=0 -> IDLE.
  PASS: tready = !full; beats are pushed. Accepted SOF with enable=1: push, FRAME_COUNT+1. Accepted SOF with enable=0: discard, count a drop, -> IDLE. This gives a frame-aligned stop.
- enable deasserted mid-frame: the current frame completes and the FIFO drains normally; it is never flushed except by reset.
- Full: tready=0 in PASS only. In IDLE/WAIT_SOF, tready stays 1 regardless of FIFO state.
- CSR map (word index):
  0 CTRL RW: bit0 enable. bit1 clear_counters is write-1 self-clearing; it zeroes FRAME_COUNT and DROP_COUNT. If clear and increment hit the same cycle, clear wins.
  1 STATUS RO: [1:0] state, [2] empty, [3] full, [16:8] fill level.
  2 FRAME_COUNT RO, 32-bit, wraps.
  3 DROP_COUNT RO, 32-bit, wraps.
  4 PARAMS RO: [7:0] DATA_W, [16:8] FIFO_DEPTH.
  Other addresses: reads return 0, writes are ignored.
- csr_readdata updates the cycle after csr_read and holds until the next read. A CSR write to CTRL takes effect in the FSM on the following cycle.

Optional Feature:
Macro STATUS_LED_EN. When defined, a LED_DIV_W-bit counter increments on each FRAME_COUNT increment, and status_led toggles when it wraps to 0. When undefined, status_led is tied to 0 and the counter is absent.

Test Plan:
- Reset, then stream 10 beats with enable=0 -> tready=1 throughout; no source valid; DROP_COUNT=10; FRAME_COUNT=0.
- Write CTRL=1. Send 3 non-SOF beats, then a 2-line frame (4 beats/line, SOF on first beat, tlast on beats 4 and 8) with ready=1 -> 3 drops; 8 beats out in order; sop on beat 1, eop on beats 4 and 8; FRAME_COUNT=1.
- Hold source ready=0 in PASS and push 20 beats with FIFO_DEPTH=16 -> tready falls after 16 accepted; STATUS.full=1, level=16. Release ready -> all 20 beats out, no loss or duplication.
- Write CTRL=0 mid-frame, then send the remainder plus the next SOF -> remainder passed; next SOF dropped; state=IDLE; DROP_COUNT+1.
- Write CTRL=0x3 during a cycle where a drop occurs -> both counters read 0 afterwards; enable=1.
- With STATUS_LED_EN and LED_DIV_W=1, pass 4 frames -> status_led toggles twice, ending at 0. Without the macro -> status_led constantly 0.
